// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: cache-wait stalls, branch flush, load-use bubble and valid tracking.
// Optional stall-cycle counter is built only when PIPE_STALL_CNT_EN is defined.
module pipeline_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_resp,
   input  logic        data_read,
   input  logic        data_write,
   input  logic        data_resp,
   input  logic        branch_taken,
   input  logic        load_use,
   output logic        inst_read,
   output logic        load_pc,
   output logic        load_decode,
   output logic        load_execute,
   output logic        load_memory,
   output logic        load_writeback,
   output logic        flush_decode,
   output logic        flush_execute,
   output logic        valid_decode,
   output logic        valid_execute,
   output logic        valid_memory,
   output logic        valid_writeback,
   output logic [31:0] stall_count
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state_r;
   state_t state_next_s;

   logic imem_done_r;
   logic dmem_done_r;
   logic valid_decode_r;
   logic valid_execute_r;
   logic valid_memory_r;
   logic valid_writeback_r;

   logic run_s;
   logic imem_wait_s;
   logic dmem_wait_s;
   logic stall_s;
   logic branch_s;
   logic hazard_s;
   logic bubble_s;

   logic inst_read_s;
   logic load_pc_s;
   logic load_decode_s;
   logic load_execute_s;
   logic load_memory_s;
   logic load_writeback_s;
   logic flush_decode_s;
   logic flush_execute_s;

   // Control state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state: one settling cycle in IDLE, then RUN until reset.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    state_next_s = RUN;
         RUN:     state_next_s = RUN;
         default: state_next_s = IDLE;
      endcase
   end

   // Hazard and wait qualification; a response arriving this cycle satisfies its own wait.
   always_comb begin
      run_s       = (state_r == RUN);
      imem_wait_s = run_s & ~imem_done_r & ~inst_resp;
      dmem_wait_s = valid_memory_r & (data_read | data_write) & ~dmem_done_r & ~data_resp;
      stall_s     = imem_wait_s | dmem_wait_s;
      branch_s    = valid_execute_r & branch_taken;
      hazard_s    = valid_decode_r & load_use;
      bubble_s    = run_s & ~stall_s & ~branch_s & hazard_s;
   end

   // Output decode: stall freezes everything, branch outranks the load-use bubble.
   always_comb begin
      inst_read_s      = 1'b0;
      load_pc_s        = 1'b0;
      load_decode_s    = 1'b0;
      load_execute_s   = 1'b0;
      load_memory_s    = 1'b0;
      load_writeback_s = 1'b0;
      flush_decode_s   = 1'b0;
      flush_execute_s  = 1'b0;
      case (state_r)
         RUN: begin
            inst_read_s = ~imem_done_r;
            if (stall_s) begin
               load_pc_s = 1'b0;
            end else if (branch_s) begin
               load_pc_s        = 1'b1;
               load_decode_s    = 1'b1;
               load_execute_s   = 1'b1;
               load_memory_s    = 1'b1;
               load_writeback_s = 1'b1;
               flush_decode_s   = 1'b1;
               flush_execute_s  = 1'b1;
            end else if (bubble_s) begin
               load_execute_s   = 1'b1;
               load_memory_s    = 1'b1;
               load_writeback_s = 1'b1;
               flush_execute_s  = 1'b1;
            end else begin
               load_pc_s        = 1'b1;
               load_decode_s    = 1'b1;
               load_execute_s   = 1'b1;
               load_memory_s    = 1'b1;
               load_writeback_s = 1'b1;
            end
         end
         IDLE: begin
            inst_read_s = 1'b0;
         end
         default: begin
            inst_read_s = 1'b0;
         end
      endcase
   end

   // Completion flags remember an early response only while the pipeline is still held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imem_done_r <= 1'b0;
         dmem_done_r <= 1'b0;
      end else begin
         imem_done_r <= stall_s & (imem_done_r | inst_resp);
         dmem_done_r <= stall_s & (dmem_done_r | data_resp);
      end
   end

   // Valid chain; each stage flag moves only with its pipeline register enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_decode_r    <= 1'b0;
         valid_execute_r   <= 1'b0;
         valid_memory_r    <= 1'b0;
         valid_writeback_r <= 1'b0;
      end else begin
         if (load_decode_s) begin
            valid_decode_r <= ~flush_decode_s;
         end
         if (load_execute_s) begin
            valid_execute_r <= valid_decode_r & ~flush_execute_s;
         end
         if (load_memory_s) begin
            valid_memory_r <= valid_execute_r;
         end
         if (load_writeback_s) begin
            valid_writeback_r <= valid_memory_r;
         end
      end
   end

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_count_r;

   // Lost-cycle counter: cache waits plus load-use bubbles, free-running wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count_r <= 32'd0;
      end else if (run_s & (stall_s | bubble_s)) begin
         stall_count_r <= stall_count_r + 32'd1;
      end
   end

   assign stall_count = stall_count_r;
`else
   assign stall_count = 32'd0;
`endif

   assign inst_read       = inst_read_s;
   assign load_pc         = load_pc_s;
   assign load_decode     = load_decode_s;
   assign load_execute    = load_execute_s;
   assign load_memory     = load_memory_s;
   assign load_writeback  = load_writeback_s;
   assign flush_decode    = flush_decode_s;
   assign flush_execute   = flush_execute_s;
   assign valid_decode    = valid_decode_r;
   assign valid_execute   = valid_execute_r;
   assign valid_memory    = valid_memory_r;
   assign valid_writeback = valid_writeback_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; stall_count expectations follow PIPE_STALL_CNT_EN.
module tb_pipeline_ctrl;

   logic        clk;
   logic        rst;
   logic        inst_resp;
   logic        data_read;
   logic        data_write;
   logic        data_resp;
   logic        branch_taken;
   logic        load_use;
   logic        inst_read;
   logic        load_pc;
   logic        load_decode;
   logic        load_execute;
   logic        load_memory;
   logic        load_writeback;
   logic        flush_decode;
   logic        flush_execute;
   logic        valid_decode;
   logic        valid_execute;
   logic        valid_memory;
   logic        valid_writeback;
   logic [31:0] stall_count;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef PIPE_STALL_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   pipeline_ctrl dut (
      .clk(clk), .rst(rst), .inst_resp(inst_resp), .data_read(data_read),
      .data_write(data_write), .data_resp(data_resp), .branch_taken(branch_taken),
      .load_use(load_use), .inst_read(inst_read), .load_pc(load_pc),
      .load_decode(load_decode), .load_execute(load_execute), .load_memory(load_memory),
      .load_writeback(load_writeback), .flush_decode(flush_decode),
      .flush_execute(flush_execute), .valid_decode(valid_decode),
      .valid_execute(valid_execute), .valid_memory(valid_memory),
      .valid_writeback(valid_writeback), .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_sc(input int n);
      return CNT_ON ? 32'(n) : 32'd0;
   endfunction

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; inst_resp = 1'b0; data_read = 1'b0; data_write = 1'b0;
      data_resp = 1'b0; branch_taken = 1'b0; load_use = 1'b0;
      #3;
      check_val("rst_load_pc", 32'(load_pc), 32'd0);
      check_val("rst_inst_read", 32'(inst_read), 32'd0);
      check_val("rst_valid_wb", 32'(valid_writeback), 32'd0);
      check_val("rst_stall_count", stall_count, 32'd0);
      tick();
      check_val("rst_held_load_wb", 32'(load_writeback), 32'd0);

      // Startup with an always-ready I-cache
      rst = 1'b0; inst_resp = 1'b1; #1;
      check_val("idle_load_pc", 32'(load_pc), 32'd0);
      check_val("idle_inst_read", 32'(inst_read), 32'd0);
      tick(); #1;
      check_val("run1_load_pc", 32'(load_pc), 32'd1);
      check_val("run1_inst_read", 32'(inst_read), 32'd1);
      check_val("run1_valid_dec", 32'(valid_decode), 32'd0);
      tick(); #1;
      check_val("run2_valid_dec", 32'(valid_decode), 32'd1);
      tick(); #1;
      check_val("run3_valid_ex", 32'(valid_execute), 32'd1);
      tick(); #1;
      check_val("run4_valid_mem", 32'(valid_memory), 32'd1);
      check_val("run4_valid_wb", 32'(valid_writeback), 32'd0);
      tick(); #1;
      check_val("run5_valid_wb", 32'(valid_writeback), 32'd1);

      // I-cache miss for three cycles
      tick(); inst_resp = 1'b0; #1;
      check_val("imiss1_load_pc", 32'(load_pc), 32'd0);
      check_val("imiss1_inst_read", 32'(inst_read), 32'd1);
      tick(); #1;
      check_val("imiss2_load_wb", 32'(load_writeback), 32'd0);
      tick(); #1;
      check_val("imiss3_load_dec", 32'(load_decode), 32'd0);
      check_val("imiss3_valid_wb", 32'(valid_writeback), 32'd1);
      tick(); inst_resp = 1'b1; #1;
      check_val("imiss4_load_pc", 32'(load_pc), 32'd1);
      check_val("imiss4_stall_count", stall_count, exp_sc(3));

      // D-cache answers first (cycle 2), I-cache at cycle 4
      tick(); inst_resp = 1'b0; data_read = 1'b1; data_resp = 1'b0; #1;
      check_val("dfirst1_load_mem", 32'(load_memory), 32'd0);
      tick(); data_resp = 1'b1; #1;
      check_val("dfirst2_load_pc", 32'(load_pc), 32'd0);
      tick(); data_resp = 1'b0; #1;
      check_val("dfirst3_load_pc", 32'(load_pc), 32'd0);
      check_val("dfirst3_inst_read", 32'(inst_read), 32'd1);
      tick(); inst_resp = 1'b1; #1;
      check_val("dfirst4_load_pc", 32'(load_pc), 32'd1);
      check_val("dfirst4_load_wb", 32'(load_writeback), 32'd1);

      // I-cache answers first, D-cache at cycle 3
      tick(); inst_resp = 1'b1; data_resp = 1'b0; #1;
      check_val("ifirst1_load_pc", 32'(load_pc), 32'd0);
      tick(); inst_resp = 1'b0; #1;
      check_val("ifirst2_inst_read", 32'(inst_read), 32'd0);
      check_val("ifirst2_load_pc", 32'(load_pc), 32'd0);
      tick(); data_resp = 1'b1; #1;
      check_val("ifirst3_load_pc", 32'(load_pc), 32'd1);
      check_val("ifirst3_inst_read", 32'(inst_read), 32'd0);

      // Both responses in the same cycle: advance, no flag left behind
      tick(); inst_resp = 1'b1; data_resp = 1'b1; #1;
      check_val("both_load_pc", 32'(load_pc), 32'd1);
      check_val("both_inst_read", 32'(inst_read), 32'd1);
      tick(); inst_resp = 1'b0; data_resp = 1'b0; data_read = 1'b0; #1;
      check_val("both_next_inst_read", 32'(inst_read), 32'd1);
      check_val("both_next_load_pc", 32'(load_pc), 32'd0);
      tick(); inst_resp = 1'b1; #1;
      check_val("resume_stall_count", stall_count, exp_sc(9));

      // Load-use bubble
      tick(); load_use = 1'b1; #1;
      check_val("lu_load_pc", 32'(load_pc), 32'd0);
      check_val("lu_load_dec", 32'(load_decode), 32'd0);
      check_val("lu_load_ex", 32'(load_execute), 32'd1);
      check_val("lu_load_mem", 32'(load_memory), 32'd1);
      check_val("lu_flush_ex", 32'(flush_execute), 32'd1);
      check_val("lu_flush_dec", 32'(flush_decode), 32'd0);
      tick(); load_use = 1'b0; #1;
      check_val("lu_next_valid_ex", 32'(valid_execute), 32'd0);
      check_val("lu_next_valid_dec", 32'(valid_decode), 32'd1);
      check_val("lu_next_stall_count", stall_count, exp_sc(10));

      // Branch and load-use together: branch wins
      tick(); branch_taken = 1'b1; load_use = 1'b1; #1;
      check_val("br_valid_ex", 32'(valid_execute), 32'd1);
      check_val("br_flush_dec", 32'(flush_decode), 32'd1);
      check_val("br_flush_ex", 32'(flush_execute), 32'd1);
      check_val("br_load_pc", 32'(load_pc), 32'd1);
      check_val("br_load_dec", 32'(load_decode), 32'd1);
      tick(); #1;
      check_val("br_next_valid_dec", 32'(valid_decode), 32'd0);
      check_val("br_next_valid_ex", 32'(valid_execute), 32'd0);
      check_val("br_ignored_flush_dec", 32'(flush_decode), 32'd0);
      check_val("lu_ignored_flush_ex", 32'(flush_execute), 32'd0);
      check_val("lu_ignored_load_pc", 32'(load_pc), 32'd1);
      tick(); branch_taken = 1'b0; load_use = 1'b0; #1;
      check_val("br_stall_count", stall_count, exp_sc(10));

      // Refill, then reset in the middle of a D-cache stall
      tick(); #1;
      tick(); data_read = 1'b1; data_resp = 1'b0; inst_resp = 1'b1; #1;
      check_val("dstall_valid_mem", 32'(valid_memory), 32'd1);
      check_val("dstall_load_pc", 32'(load_pc), 32'd0);
      tick(); inst_resp = 1'b0; #1;
      check_val("dstall_inst_read", 32'(inst_read), 32'd0);
      rst = 1'b1; #1;
      check_val("midrst_load_ex", 32'(load_execute), 32'd0);
      check_val("midrst_inst_read", 32'(inst_read), 32'd0);
      check_val("midrst_valid_mem", 32'(valid_memory), 32'd0);
      check_val("midrst_valid_wb", 32'(valid_writeback), 32'd0);
      check_val("midrst_stall_count", stall_count, 32'd0);
      tick(); rst = 1'b0; #1;
      check_val("post_idle_inst_read", 32'(inst_read), 32'd0);
      check_val("post_idle_load_pc", 32'(load_pc), 32'd0);
      tick(); #1;
      check_val("post_run_inst_read", 32'(inst_read), 32'd1);
      check_val("post_run_load_pc", 32'(load_pc), 32'd0);
      tick(); inst_resp = 1'b1; #1;
      check_val("post_resume_load_pc", 32'(load_pc), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port inst_resp  input  1  I-cache one-cycle completion pulse for the current fetch.
REQ-004 SHALL have port data_read / data_write  input  1 each  MEM-stage memory request from datapath.
REQ-005 SHALL have port data_resp  input  1  D-cache one-cycle completion pulse.
REQ-006 SHALL have port branch_taken  input  1  EX-stage redirect; ignored unless valid_execute=1.
REQ-007 SHALL have port load_use  input  1  ID-stage load-use hazard; ignored unless valid_decode=1.
REQ-008 SHALL have port inst_read  output  1  I-cache fetch request.
REQ-009 SHALL have ports load_pc, load_decode, load_execute, load_memory, load_writeback  output  1 each  pipeline register enables.
REQ-010 SHALL have ports flush_decode, flush_execute  output  1 each  bubble insert into IF/ID, ID/EX.
REQ-011 SHALL have ports valid_decode, valid_execute, valid_memory, valid_writeback  output  1 each  stage-holds-real-instruction flags.
REQ-012 SHALL have port stall_count  output  32  stall-cycle counter (see Configuration).

Function
REQ-013 SHALL implement FSM {IDLE, RUN}; IDLE -> RUN unconditionally after one cycle; RUN holds until reset.
REQ-014 inst_read SHALL be 1 only in RUN and when imem_done=0.
REQ-015 SHALL define imem_wait = RUN & ~imem_done & ~inst_resp; dmem_wait = valid_memory & (data_read|data_write) & ~dmem_done & ~data_resp; stall = imem_wait | dmem_wait.
REQ-016 imem_done SHALL set on inst_resp while stall=1; dmem_done SHALL set on data_resp while stall=1; both clear on any cycle with stall=0.
REQ-017 When stall=1 or state=IDLE: all load_* = 0, flush_* = 0.
REQ-018 When stall=0 and valid branch_taken: all load_* = 1, flush_decode=1, flush_execute=1 (branch priority over load_use).
REQ-019 When stall=0, no branch, valid load_use: load_pc=0, load_decode=0, load_execute=load_memory=load_writeback=1, flush_execute=1.
REQ-020 Otherwise (stall=0, RUN): all load_* = 1, flush_* = 0.
REQ-021 Valid chain, updated only when respective load_* = 1: valid_decode <= ~flush_decode; valid_execute <= valid_decode & ~flush_execute; valid_memory <= valid_execute; valid_writeback <= valid_memory.
REQ-022 inst_resp and data_resp same cycle with no other stall SHALL advance pipeline that cycle, no done flag set.
REQ-023 All outputs SHALL be combinational from registered state and inputs except valid_*, stall_count (registered).

Reset
REQ-024 On rst: state=IDLE, imem_done=dmem_done=0, valid_*=0, stall_count=0; all load_*, flush_*, inst_read = 0 while rst=1.
REQ-025 Reset asserted mid-stall SHALL discard outstanding done flags; first post-reset fetch begins after IDLE cycle.

Configuration
REQ-026 Macro PIPE_STALL_CNT_EN defined: stall_count increments by 1 each RUN cycle with stall=1 or load_use bubble, wraps 0xFFFFFFFF -> 0.
REQ-027 Macro undefined: stall_count SHALL be constant 0, no counter register synthesized.

Verification
REQ-028 Reset release, inst_resp every cycle -> cycle 1 IDLE all loads 0; valid_writeback=1 at 5th RUN cycle.
REQ-029 inst_resp delayed 3 cycles -> all loads 0 for 3 cycles, stall_count=3 (macro on), resume cycle 4.
REQ-030 data_read with data_resp at cycle 2 while inst_resp arrives cycle 4 -> dmem_done=1 cycles 3-4, single advance at cycle 4, inst_read low after inst_resp... held until advance.
REQ-031 valid load_use, no stall -> load_pc=load_decode=0, flush_execute=1, valid_execute=0 next cycle, ID instruction retained.
REQ-032 branch_taken with load_use same cycle -> flush_decode=flush_execute=1, load_pc=1, valid_decode=valid_execute=0 next cycle.
REQ-033 rst asserted during dmem stall -> all outputs 0 immediately, done flags 0, IDLE one cycle after release.
